stack_cpu_controller: RTL and testbench

//  Multicycle Moore FSM that sequences the stack-machine datapath: fetch, decode on the
//  3-bit opcode, then per-instruction stack/memory/ALU/PC control. Sits beside the

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/stack_cpu_controller.sv | 147 ++++++++++++++
 tb/tb_stack_cpu_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the stack CPU: opcodes, ALU operations, controller states
// and the bundle of control strobes the controller drives into the datapath.
package cpu_pkg;

  localparam int OPC_W   = 3;
  localparam int ALUOP_W = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOT  = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_POP_A, S_POP_B, S_EXEC, S_WB_ALU,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_JUMP, S_PEEK, S_BRZ
  } state_e;

  typedef struct packed {
    logic [1:0] aluop;
    logic       pc_write_uncond;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mtos;
    logic       push;
    logic       pop;
    logic       tos;
    logic       lda;
    logic       ldb;
    logic       src_a;
    logic       src_b;
    logic       pc_src;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/stack_cpu_controller.sv
// Multicycle Moore controller for the stack CPU. Outputs are registered from
// the decode of the next state, so they always reflect the current state.
module stack_cpu_controller
  import cpu_pkg::*;
#(
  parameter int OPC_W   = 3,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opc,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               pcWriteUnCond,
  output logic               pcWriteCond,
  output logic               IorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               IRWrite,
  output logic               MtoS,
  output logic               push,
  output logic               pop,
  output logic               tos,
  output logic               ldA,
  output logic               ldB,
  output logic               srcA,
  output logic               srcB,
  output logic               pcSrc,
  output logic               instr_done,
  output logic [3:0]         state_dbg
);

  state_e state, state_nxt;
  ctrl_t  ctrl, ctrl_nxt;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode_e'(opc[2:0]))
          OP_PUSH: state_nxt = S_MEM_RD;
          OP_JMP:  state_nxt = S_JUMP;
          OP_JZ:   state_nxt = S_PEEK;
          default: state_nxt = S_POP_A;
        endcase
      end
      S_POP_A: begin
        case (opcode_e'(opc[2:0]))
          OP_NOT:  state_nxt = S_EXEC;
          OP_POP:  state_nxt = S_MEM_WR;
          default: state_nxt = S_POP_B;
        endcase
      end
      S_POP_B:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB_ALU;
      S_MEM_RD: state_nxt = S_WB_MEM;
      S_PEEK:   state_nxt = S_BRZ;
      S_WB_ALU, S_WB_MEM, S_MEM_WR, S_JUMP, S_BRZ: state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // IR is loaded at the end of FETCH, so opc is stable when EXEC is entered.
  always_comb begin
    ctrl_nxt = '0;
    case (state_nxt)
      S_FETCH: begin
        ctrl_nxt.mem_read        = 1'b1;
        ctrl_nxt.ir_write        = 1'b1;
        ctrl_nxt.src_a           = 1'b1;
        ctrl_nxt.src_b           = 1'b1;
        ctrl_nxt.aluop           = ALU_ADD;
        ctrl_nxt.pc_write_uncond = 1'b1;
      end
      S_POP_A: begin
        ctrl_nxt.pop = 1'b1;
        ctrl_nxt.lda = 1'b1;
      end
      S_POP_B: begin
        ctrl_nxt.pop = 1'b1;
        ctrl_nxt.ldb = 1'b1;
      end
      S_EXEC:   ctrl_nxt.aluop = opc[1:0];
      S_WB_ALU: begin
        ctrl_nxt.push       = 1'b1;
        ctrl_nxt.instr_done = 1'b1;
      end
      S_MEM_RD: begin
        ctrl_nxt.iord     = 1'b1;
        ctrl_nxt.mem_read = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_nxt.mtos       = 1'b1;
        ctrl_nxt.push       = 1'b1;
        ctrl_nxt.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_nxt.iord       = 1'b1;
        ctrl_nxt.mem_write  = 1'b1;
        ctrl_nxt.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_nxt.pc_src          = 1'b1;
        ctrl_nxt.pc_write_uncond = 1'b1;
        ctrl_nxt.instr_done      = 1'b1;
      end
      S_PEEK:   ctrl_nxt.tos = 1'b1;
      S_BRZ: begin
        ctrl_nxt.pc_src        = 1'b1;
        ctrl_nxt.pc_write_cond = 1'b1;
        ctrl_nxt.instr_done    = 1'b1;
      end
      default: ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_nxt;
    end
  end

  assign ALUOP         = ctrl.aluop;
  assign pcWriteUnCond = ctrl.pc_write_uncond;
  assign pcWriteCond   = ctrl.pc_write_cond;
  assign IorD          = ctrl.iord;
  assign memRead       = ctrl.mem_read;
  assign memWrite      = ctrl.mem_write;
  assign IRWrite       = ctrl.ir_write;
  assign MtoS          = ctrl.mtos;
  assign push          = ctrl.push;
  assign pop           = ctrl.pop;
  assign tos           = ctrl.tos;
  assign ldA           = ctrl.lda;
  assign ldB           = ctrl.ldb;
  assign srcA          = ctrl.src_a;
  assign srcB          = ctrl.src_b;
  assign pcSrc         = ctrl.pc_src;
  assign instr_done    = ctrl.instr_done;
  assign state_dbg     = state;

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Bench for stack_cpu_controller: per-instruction output scripts are queued as
// expected vectors and compared cycle by cycle against the DUT outputs.
module tb_stack_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opc = 3'b000;
  logic [1:0] ALUOP;
  logic       pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite, MtoS;
  logic       push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, instr_done;
  logic [3:0] state_dbg;

  // Bit positions of the observed control vector.
  localparam logic [17:0] B_PCU  = 18'h1 << 15;
  localparam logic [17:0] B_PCC  = 18'h1 << 14;
  localparam logic [17:0] B_IORD = 18'h1 << 13;
  localparam logic [17:0] B_MRD  = 18'h1 << 12;
  localparam logic [17:0] B_MWR  = 18'h1 << 11;
  localparam logic [17:0] B_IRW  = 18'h1 << 10;
  localparam logic [17:0] B_MTOS = 18'h1 << 9;
  localparam logic [17:0] B_PUSH = 18'h1 << 8;
  localparam logic [17:0] B_POP  = 18'h1 << 7;
  localparam logic [17:0] B_TOS  = 18'h1 << 6;
  localparam logic [17:0] B_LDA  = 18'h1 << 5;
  localparam logic [17:0] B_LDB  = 18'h1 << 4;
  localparam logic [17:0] B_SRCA = 18'h1 << 3;
  localparam logic [17:0] B_SRCB = 18'h1 << 2;
  localparam logic [17:0] B_PCS  = 18'h1 << 1;
  localparam logic [17:0] B_DONE = 18'h1;

  logic [17:0] obs;
  assign obs = {ALUOP, pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite,
                MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, instr_done};

  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_instr  = 0;
  logic [3:0] idle_dbg;

  stack_cpu_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .ALUOP(ALUOP),
    .pcWriteUnCond(pcWriteUnCond), .pcWriteCond(pcWriteCond), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
    .push(push), .pop(pop), .tos(tos), .ldA(ldA), .ldB(ldB),
    .srcA(srcA), .srcB(srcB), .pcSrc(pcSrc), .instr_done(instr_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  a_push_pop: assert property (@(posedge clk) disable iff (rst) !(push && pop));
  a_rd_wr:    assert property (@(posedge clk) disable iff (rst) !(memRead && memWrite));
  a_done_1:   assert property (@(posedge clk) disable iff (rst) instr_done |=> !instr_done);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
  endtask

  // Reference model: the control script of each instruction, one vector per cycle.
  task automatic model_instr(input logic [2:0] op);
    logic [17:0] fetch_v;
    logic [17:0] alu_v;
    fetch_v = B_MRD | B_IRW | B_SRCA | B_SRCB | B_PCU;
    alu_v   = {op[1:0], 16'h0};
    exp_q.push_back(fetch_v);
    exp_q.push_back(18'h0);
    case (op)
      3'd0, 3'd1, 3'd2: begin
        exp_q.push_back(B_POP | B_LDA);
        exp_q.push_back(B_POP | B_LDB);
        exp_q.push_back(alu_v);
        exp_q.push_back(B_PUSH | B_DONE);
      end
      3'd3: begin
        exp_q.push_back(B_POP | B_LDA);
        exp_q.push_back(alu_v);
        exp_q.push_back(B_PUSH | B_DONE);
      end
      3'd4: begin
        exp_q.push_back(B_IORD | B_MRD);
        exp_q.push_back(B_MTOS | B_PUSH | B_DONE);
      end
      3'd5: begin
        exp_q.push_back(B_POP | B_LDA);
        exp_q.push_back(B_IORD | B_MWR | B_DONE);
      end
      3'd6: exp_q.push_back(B_PCS | B_PCU | B_DONE);
      default: begin
        exp_q.push_back(B_TOS);
        exp_q.push_back(B_PCS | B_PCC | B_DONE);
      end
    endcase
  endtask

  // Drives one instruction: opc appears during FETCH as the IR load would make it.
  // Stops after max_cycles vectors (remaining expectations are discarded).
  task automatic run_instr(input logic [2:0] op, input int max_cycles);
    int i;
    logic [17:0] e;
    string tag;
    model_instr(op);
    i = 0;
    while (exp_q.size() > 0 && i < max_cycles) begin
      @(negedge clk);
      if (i == 0) opc = op;
      e = exp_q.pop_front();
      tag = $sformatf("op%0d_cyc%0d", op, i);
      check(tag, {14'h0, obs}, {14'h0, e});
      i++;
    end
    exp_q.delete();
    n_instr++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check({tag, "_hold"}, {14'h0, obs}, 32'h0);
    end
    rst = 1'b0;
    check({tag, "_idle"}, {14'h0, obs}, 32'h0);
  endtask

  initial begin
    logic [2:0] dir_ops[8];
    dir_ops = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd1, 3'd2};

    do_reset("rst0");
    idle_dbg = state_dbg;
    foreach (dir_ops[k]) run_instr(dir_ops[k], 100);

    for (int k = 0; k < 40; k++) run_instr(3'($urandom_range(0, 7)), 100);

    // Abort a SUB in EXEC (FETCH, DECODE, POP_A, POP_B, EXEC = 5 cycles).
    run_instr(3'd1, 5);
    #2 rst = 1'b1;
    #1 check("rst_async", {14'h0, obs}, 32'h0);
    do_reset("rst1");
    check("rst_state_repeat", {28'h0, state_dbg}, {28'h0, idle_dbg});

    for (int k = 0; k < 20; k++) run_instr(3'($urandom_range(0, 7)), 100);
    run_instr(3'd6, 100);

    // The instruction after the last one must start with a clean FETCH.
    @(negedge clk);
    check("final_fetch", {14'h0, obs}, {14'h0, B_MRD | B_IRW | B_SRCA | B_SRCB | B_PCU});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
